// File: rtl/cxu_pkg.sv
// Shared CXU-LI definitions: status field width, status codes and the width helper
// used by the arbiter and its tag FIFO.
package cxu_pkg;

   localparam int CXU_STATUS_W = 3;

   typedef enum logic [CXU_STATUS_W-1:0] {
      CXU_STATUS_OK      = 3'd0,
      CXU_STATUS_ERROR   = 3'd1,
      CXU_STATUS_PENDING = 3'd2,
      CXU_STATUS_OFF     = 3'd3
   } cxu_status_e;

   // MSB index for a field of width w; a zero-width request still yields a 1-bit field.
   function automatic int common_pkg_msb(input int w);
      return (w > 1) ? (w - 1) : 0;
   endfunction

endpackage

// File: rtl/cxu_tag_fifo.sv
// In-order FIFO of granted initiator indices used to route target responses back.
// A push and a pop in the same cycle leave the occupancy unchanged.
module cxu_tag_fifo
   import cxu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 2
) (
   input  logic         clk_sys,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] push_data,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int PTR_MSB = common_pkg_msb(PTR_W);
   localparam int CNT_W   = PTR_W + 1;

   logic [W-1:0]       mem_q [DEPTH];
   logic [W-1:0]       mem_d [DEPTH];
   logic [PTR_MSB:0]   wr_q, wr_d;
   logic [PTR_MSB:0]   rd_q, rd_d;
   logic [CNT_W-1:0]   count_q, count_d;

   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (push) begin
         mem_d[wr_q] = push_data;
         wr_d        = wr_q + 1'b1;
      end
      if (pop) begin
         rd_d = rd_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         mem_q   <= '{default: '0};
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   assign head  = mem_q[rd_q];
   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);

endmodule

// File: rtl/cxu_rr_arbiter.sv
// Round-robin arbiter sharing one CXU-LI target port among N_INIS initiators;
// responses return in issue order via a tag FIFO of granted indices.
module cxu_rr_arbiter
   import cxu_pkg::*;
#(
   parameter int N_INIS        = 4,
   parameter int MAX_OUT       = 4,
   parameter int CXU_CXU_ID_W  = 2,
   parameter int CXU_FUNC_ID_W = 3,
   parameter int CXU_DATA_W    = 32
) (
   input  logic                              UserCLK,
   input  logic                              rst_n,
   input  logic                              UserCLK_en,
   input  logic [N_INIS-1:0]                 i_req_valids,
   output logic [N_INIS-1:0]                 i_req_readys,
   input  logic [N_INIS*CXU_CXU_ID_W-1:0]    i_req_cxus,
   input  logic [N_INIS*CXU_FUNC_ID_W-1:0]   i_req_funcs,
   input  logic [N_INIS*CXU_DATA_W-1:0]      i_req_data0s,
   input  logic [N_INIS*CXU_DATA_W-1:0]      i_req_data1s,
   output logic [N_INIS-1:0]                 i_resp_valids,
   input  logic [N_INIS-1:0]                 i_resp_readys,
   output logic [N_INIS*CXU_STATUS_W-1:0]    i_resp_statuss,
   output logic [N_INIS*CXU_DATA_W-1:0]      i_resp_datas,
   output logic                              t_req_valid,
   input  logic                              t_req_ready,
   output logic [CXU_CXU_ID_W-1:0]           t_req_cxu,
   output logic [CXU_FUNC_ID_W-1:0]          t_req_func,
   output logic [CXU_DATA_W-1:0]             t_req_data0,
   output logic [CXU_DATA_W-1:0]             t_req_data1,
   input  logic                              t_resp_valid,
   output logic                              t_resp_ready,
   input  logic [CXU_STATUS_W-1:0]           t_resp_status,
   input  logic [CXU_DATA_W-1:0]             t_resp_data,
   output logic                              err_unexp_resp
);

   localparam int IDX_W   = $clog2(N_INIS);
   localparam int IDX_MSB = common_pkg_msb(IDX_W);

   logic [IDX_MSB:0] ptr_q, ptr_d;
   logic [IDX_MSB:0] lock_idx_q, lock_idx_d;
   logic             lock_q, lock_d;
   logic             err_q, err_d;
   logic [IDX_MSB:0] grant_idx;
   logic [IDX_MSB:0] head_idx;
   logic             fifo_full, fifo_empty;
   logic             req_fire, resp_fire;
   logic             found;
   int               cand;
   int               gi;

   // A stalled grant stays locked so the forwarded fields cannot change under the target.
   always_comb begin
      grant_idx = ptr_q;
      found     = 1'b0;
      cand      = 0;
      if (lock_q) begin
         grant_idx = lock_idx_q;
      end else begin
         for (int i = 0; i < N_INIS; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= N_INIS) cand = cand - N_INIS;
            if (!found && i_req_valids[cand]) begin
               found     = 1'b1;
               grant_idx = IDX_W'(cand);
            end
         end
      end
   end

   assign gi          = int'(grant_idx);
   assign t_req_valid = UserCLK_en & (|i_req_valids) & ~fifo_full;
   assign t_req_cxu   = i_req_cxus[gi*CXU_CXU_ID_W +: CXU_CXU_ID_W];
   assign t_req_func  = i_req_funcs[gi*CXU_FUNC_ID_W +: CXU_FUNC_ID_W];
   assign t_req_data0 = i_req_data0s[gi*CXU_DATA_W +: CXU_DATA_W];
   assign t_req_data1 = i_req_data1s[gi*CXU_DATA_W +: CXU_DATA_W];
   assign req_fire    = t_req_valid & t_req_ready;

   always_comb begin
      i_req_readys            = '0;
      i_req_readys[grant_idx] = req_fire;
   end

   // Only the valid bit is steered; status and data go to every initiator slice.
   always_comb begin
      i_resp_valids           = '0;
      i_resp_valids[head_idx] = t_resp_valid & ~fifo_empty & UserCLK_en;
   end

   assign t_resp_ready   = i_resp_readys[head_idx] & ~fifo_empty & UserCLK_en;
   assign resp_fire      = t_resp_valid & t_resp_ready;
   assign i_resp_statuss = {N_INIS{t_resp_status}};
   assign i_resp_datas   = {N_INIS{t_resp_data}};

   always_comb begin
      ptr_d      = ptr_q;
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      err_d      = err_q;
      if (req_fire) begin
         ptr_d  = (gi == N_INIS - 1) ? '0 : grant_idx + 1'b1;
         lock_d = 1'b0;
      end else if (t_req_valid) begin
         lock_d     = 1'b1;
         lock_idx_d = grant_idx;
      end
      if (UserCLK_en && t_resp_valid && fifo_empty) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge UserCLK or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q      <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         err_q      <= 1'b0;
      end else begin
         ptr_q      <= ptr_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
         err_q      <= err_d;
      end
   end

   assign err_unexp_resp = err_q;

   cxu_tag_fifo #(
      .DEPTH (MAX_OUT),
      .W     (IDX_W)
   ) u_tag_fifo (
      .clk_sys   (UserCLK),
      .rst_n     (rst_n),
      .push      (req_fire),
      .pop       (resp_fire),
      .push_data (grant_idx),
      .head      (head_idx),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_cxu_rr_arbiter.sv
// Directed bench for cxu_rr_arbiter: grant rotation, lock, full stall, response routing,
// unexpected responses, clock enable and reset behaviour.
module tb_cxu_rr_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;

   logic            clk;
   logic            rst_n;
   logic            en;
   logic [N-1:0]    i_req_valids;
   logic [N-1:0]    i_req_readys;
   logic [N*2-1:0]  i_req_cxus;
   logic [N*3-1:0]  i_req_funcs;
   logic [N*DW-1:0] i_req_data0s;
   logic [N*DW-1:0] i_req_data1s;
   logic [N-1:0]    i_resp_valids;
   logic [N-1:0]    i_resp_readys;
   logic [N*3-1:0]  i_resp_statuss;
   logic [N*DW-1:0] i_resp_datas;
   logic            t_req_valid;
   logic            t_req_ready;
   logic [1:0]      t_req_cxu;
   logic [2:0]      t_req_func;
   logic [DW-1:0]   t_req_data0;
   logic [DW-1:0]   t_req_data1;
   logic            t_resp_valid;
   logic            t_resp_ready;
   logic [2:0]      t_resp_status;
   logic [DW-1:0]   t_resp_data;
   logic            err_unexp_resp;

   int checks = 0;
   int errors = 0;

   cxu_rr_arbiter #(
      .N_INIS(N), .MAX_OUT(4), .CXU_CXU_ID_W(2), .CXU_FUNC_ID_W(3), .CXU_DATA_W(DW)
   ) dut (
      .UserCLK        (clk),
      .rst_n          (rst_n),
      .UserCLK_en     (en),
      .i_req_valids   (i_req_valids),
      .i_req_readys   (i_req_readys),
      .i_req_cxus     (i_req_cxus),
      .i_req_funcs    (i_req_funcs),
      .i_req_data0s   (i_req_data0s),
      .i_req_data1s   (i_req_data1s),
      .i_resp_valids  (i_resp_valids),
      .i_resp_readys  (i_resp_readys),
      .i_resp_statuss (i_resp_statuss),
      .i_resp_datas   (i_resp_datas),
      .t_req_valid    (t_req_valid),
      .t_req_ready    (t_req_ready),
      .t_req_cxu      (t_req_cxu),
      .t_req_func     (t_req_func),
      .t_req_data0    (t_req_data0),
      .t_req_data1    (t_req_data1),
      .t_resp_valid   (t_resp_valid),
      .t_resp_ready   (t_resp_ready),
      .t_resp_status  (t_resp_status),
      .t_resp_data    (t_resp_data),
      .err_unexp_resp (err_unexp_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      rst_n         = 1'b0;
      en            = 1'b1;
      i_req_valids  = '0;
      i_req_cxus    = '0;
      i_req_funcs   = '0;
      i_req_data0s  = '0;
      i_req_data1s  = '0;
      i_resp_readys = '0;
      t_req_ready   = 1'b0;
      t_resp_valid  = 1'b0;
      t_resp_status = '0;
      t_resp_data   = '0;
      #12;
      chk("rst_t_req_valid", t_req_valid, 0);
      chk("rst_i_req_readys", i_req_readys, 0);
      chk("rst_t_resp_ready", t_resp_ready, 0);
      chk("rst_i_resp_valids", i_resp_valids, 0);
      chk("rst_err", err_unexp_resp, 0);
      tick();
      rst_n         = 1'b1;
      i_resp_readys = '1;

      // single request from initiator 2
      i_req_valids              = 4'b0100;
      i_req_funcs[6 +: 3]       = 3'd5;
      i_req_cxus[4 +: 2]        = 2'd1;
      i_req_data0s[64 +: DW]    = 32'h11;
      i_req_data1s[64 +: DW]    = 32'h22;
      t_req_ready               = 1'b1;
      #1;
      chk("single_valid", t_req_valid, 1);
      chk("single_func", t_req_func, 5);
      chk("single_cxu", t_req_cxu, 1);
      chk("single_data0", t_req_data0, 32'h11);
      chk("single_data1", t_req_data1, 32'h22);
      chk("single_readys", i_req_readys, 4'b0100);
      tick();
      i_req_valids  = '0;
      t_resp_valid  = 1'b1;
      t_resp_data   = 32'h55;
      t_resp_status = 3'd2;
      #1;
      chk("single_resp_valids", i_resp_valids, 4'b0100);
      chk("single_t_resp_ready", t_resp_ready, 1);
      chk("single_resp_data", i_resp_datas[64 +: DW], 32'h55);
      chk("single_resp_status", i_resp_statuss[6 +: 3], 2);
      tick();
      t_resp_valid = 1'b0;
      #1;
      chk("single_drained", t_resp_ready, 0);

      // all initiators valid: rotate 0..3 then stall on full
      do_reset();
      for (int k = 0; k < N; k++) i_req_data0s[k*DW +: DW] = 32'h100 + k;
      i_req_valids = 4'b1111;
      t_req_ready  = 1'b1;
      for (int k = 0; k < N; k++) begin
         #1;
         chk($sformatf("rot_readys_%0d", k), i_req_readys, 4'b0001 << k);
         chk($sformatf("rot_data0_%0d", k), t_req_data0, 32'h100 + k);
         tick();
      end
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("full_no_valid_%0d", k), t_req_valid, 0);
         tick();
      end
      i_req_valids = 4'b0001;
      t_resp_valid = 1'b1;
      t_resp_data  = 32'hA0;
      #1;
      chk("full_until_pop", t_req_valid, 0);
      chk("resp0_valids", i_resp_valids, 4'b0001);
      chk("resp0_data", i_resp_datas[0 +: DW], 32'hA0);
      tick();
      t_resp_data = 32'hA1;
      #1;
      chk("after_pop_valid", t_req_valid, 1);
      chk("after_pop_readys", i_req_readys, 4'b0001);
      chk("resp1_valids", i_resp_valids, 4'b0010);
      tick();
      i_req_valids = '0;
      t_resp_data  = 32'hA2;
      #1;
      chk("resp2_valids", i_resp_valids, 4'b0100);
      tick();
      t_resp_data = 32'hA3;
      #1;
      chk("resp3_valids", i_resp_valids, 4'b1000);
      chk("resp3_data", i_resp_datas[96 +: DW], 32'hA3);
      tick();
      t_resp_data = 32'hA4;
      #1;
      chk("resp4_valids", i_resp_valids, 4'b0001);
      chk("resp4_data", i_resp_datas[0 +: DW], 32'hA4);
      tick();
      t_resp_valid = 1'b0;

      // grant lock while the target stalls
      do_reset();
      i_req_data0s[0 +: DW]  = 32'h200;
      i_req_data0s[DW +: DW] = 32'h201;
      i_req_valids = 4'b0010;
      t_req_ready  = 1'b0;
      #1;
      chk("lock_c1_valid", t_req_valid, 1);
      chk("lock_c1_readys", i_req_readys, 0);
      chk("lock_c1_data0", t_req_data0, 32'h201);
      tick();
      i_req_valids = 4'b0011;
      #1;
      chk("lock_c2_data0", t_req_data0, 32'h201);
      tick();
      t_req_ready = 1'b1;
      #1;
      chk("lock_c3_readys", i_req_readys, 4'b0010);
      chk("lock_c3_data0", t_req_data0, 32'h201);
      tick();
      #1;
      chk("lock_next_readys", i_req_readys, 4'b0001);
      chk("lock_next_data0", t_req_data0, 32'h200);
      tick();
      i_req_valids = '0;

      // push and pop together at count 2 (tags 1,0 outstanding)
      i_req_valids = 4'b1000;
      t_resp_valid = 1'b1;
      t_resp_data  = 32'hB0;
      #1;
      chk("pp_req_readys", i_req_readys, 4'b1000);
      chk("pp_resp_valids", i_resp_valids, 4'b0010);
      tick();
      i_req_valids = '0;
      t_resp_data  = 32'hB1;
      #1;
      chk("pp_next_head", i_resp_valids, 4'b0001);
      tick();
      t_resp_data = 32'hB2;
      #1;
      chk("pp_pushed_tag", i_resp_valids, 4'b1000);
      tick();

      // unexpected response while empty
      #1;
      chk("unexp_ready", t_resp_ready, 0);
      chk("unexp_valids", i_resp_valids, 0);
      chk("unexp_err_before", err_unexp_resp, 0);
      tick();
      chk("unexp_err_set", err_unexp_resp, 1);
      t_resp_valid = 1'b0;
      tick();
      chk("unexp_err_held", err_unexp_resp, 1);

      // clock enable low freezes everything
      en           = 1'b0;
      i_req_valids = 4'b0110;
      t_req_ready  = 1'b1;
      #1;
      chk("en0_c1_valid", t_req_valid, 0);
      chk("en0_c1_readys", i_req_readys, 0);
      tick();
      #1;
      chk("en0_c2_readys", i_req_readys, 0);
      tick();
      en = 1'b1;
      #1;
      chk("en1_readys", i_req_readys, 4'b0010);
      tick();
      i_req_valids = '0;
      #1;
      chk("en1_idle", t_req_valid, 0);

      // reset with a tag outstanding drops it
      rst_n = 1'b0;
      #1;
      chk("rst_async_err", err_unexp_resp, 0);
      tick();
      rst_n        = 1'b1;
      t_resp_valid = 1'b1;
      #1;
      chk("rst_drop_ready", t_resp_ready, 0);
      chk("rst_drop_valids", i_resp_valids, 0);
      tick();
      chk("rst_drop_err", err_unexp_resp, 1);
      t_resp_valid = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
